// File: rtl/pipelined_csel_adder.sv
`default_nettype none
// ============================================================================
//  Module      : pipelined_csel_adder
//  Description : Two-stage carry-select adder with valid/ready handshakes.
//                Optional subtract mode enabled by macro CSEL_SUB_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module pipelined_csel_adder #(
    parameter int WIDTH = 16,
    parameter int BLK   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
`ifdef CSEL_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);

    localparam int NBLK = WIDTH / BLK;

    generate
        if ((WIDTH % BLK) != 0) begin : g_bad_cfg
            $error("pipelined_csel_adder: WIDTH must be an integer multiple of BLK");
        end
    endgenerate

    logic [WIDTH-1:0] w_b_eff;
    logic             w_cin_eff;

`ifdef CSEL_SUB_EN
    // Subtraction as a + ~b + 1; c_in is ignored while sub is high.
    assign w_b_eff   = sub ? ~b : b;
    assign w_cin_eff = sub | c_in;
`else
    assign w_b_eff   = b;
    assign w_cin_eff = c_in;
`endif

    logic [WIDTH-1:0] w_sum0, w_sum1;
    logic [NBLK-1:0]  w_cy0, w_cy1;

    for (genvar i = 0; i < NBLK; i++) begin : g_blk
        logic [BLK:0] w_p0, w_p1;
        assign w_p0 = {1'b0, a[i*BLK +: BLK]} + {1'b0, w_b_eff[i*BLK +: BLK]};
        assign w_p1 = w_p0 + {{BLK{1'b0}}, 1'b1};
        assign w_sum0[i*BLK +: BLK] = w_p0[BLK-1:0];
        assign w_sum1[i*BLK +: BLK] = w_p1[BLK-1:0];
        assign w_cy0[i] = w_p0[BLK];
        assign w_cy1[i] = w_p1[BLK];
    end

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_sum0_q, s1_sum0_d, s1_sum1_q, s1_sum1_d;
    logic [NBLK-1:0]  s1_cy0_q, s1_cy0_d, s1_cy1_q, s1_cy1_d;
    logic             s1_cin_q, s1_cin_d;
    logic             s1_axb_q, s1_axb_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             c_out_q, c_out_d;
    logic             ovf_q, ovf_d;

    logic             w_s2_load;
    logic [WIDTH-1:0] w_res;
    logic             w_carry;

    assign w_s2_load = !out_valid_q || out_ready;
    assign in_ready  = !s1_valid_q || w_s2_load;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_sum0_d  = s1_sum0_q;
        s1_sum1_d  = s1_sum1_q;
        s1_cy0_d   = s1_cy0_q;
        s1_cy1_d   = s1_cy1_q;
        s1_cin_d   = s1_cin_q;
        s1_axb_d   = s1_axb_q;
        if (in_ready) begin
            s1_valid_d = in_valid;
        end
        if (in_valid && in_ready) begin
            s1_sum0_d = w_sum0;
            s1_sum1_d = w_sum1;
            s1_cy0_d  = w_cy0;
            s1_cy1_d  = w_cy1;
            s1_cin_d  = w_cin_eff;
            // Operand MSB parity lets stage 2 recover the carry into the MSB.
            s1_axb_d  = a[WIDTH-1] ^ w_b_eff[WIDTH-1];
        end
    end

    always_comb begin
        w_carry = s1_cin_q;
        w_res   = '0;
        for (int i = 0; i < NBLK; i++) begin
            if (w_carry) begin
                w_res[i*BLK +: BLK] = s1_sum1_q[i*BLK +: BLK];
                w_carry             = s1_cy1_q[i];
            end else begin
                w_res[i*BLK +: BLK] = s1_sum0_q[i*BLK +: BLK];
                w_carry             = s1_cy0_q[i];
            end
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        sum_d       = sum_q;
        c_out_d     = c_out_q;
        ovf_d       = ovf_q;
        if (w_s2_load) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                sum_d   = w_res;
                c_out_d = w_carry;
                ovf_d   = w_carry ^ (w_res[WIDTH-1] ^ s1_axb_q);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_sum0_q   <= '0;
            s1_sum1_q   <= '0;
            s1_cy0_q    <= '0;
            s1_cy1_q    <= '0;
            s1_cin_q    <= 1'b0;
            s1_axb_q    <= 1'b0;
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            c_out_q     <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_sum0_q   <= s1_sum0_d;
            s1_sum1_q   <= s1_sum1_d;
            s1_cy0_q    <= s1_cy0_d;
            s1_cy1_q    <= s1_cy1_d;
            s1_cin_q    <= s1_cin_d;
            s1_axb_q    <= s1_axb_d;
            out_valid_q <= out_valid_d;
            sum_q       <= sum_d;
            c_out_q     <= c_out_d;
            ovf_q       <= ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign c_out     = c_out_q;
    assign ovf       = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_csel_adder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipelined_csel_adder
//  Description : Directed and randomized bench for pipelined_csel_adder
//                (16/4, 8/2 and 32/8 instances; CSEL_SUB_EN adds sub vectors).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pipelined_csel_adder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        in_valid, in_ready, c_in, out_valid, out_ready, c_out, ovf;
    logic [15:0] a, b, sum;
`ifdef CSEL_SUB_EN
    logic        sub;
`endif

    logic        rv, rr;
    logic        ci8, ir8, ov8, co8, of8;
    logic [7:0]  a8, b8, s8;
    logic        ci32, ir32, ov32, co32, of32;
    logic [31:0] a32, b32, s32;

    int checks = 0;
    int errors = 0;

    pipelined_csel_adder #(.WIDTH(16), .BLK(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c_in(c_in),
`ifdef CSEL_SUB_EN
        .sub(sub),
`endif
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .c_out(c_out), .ovf(ovf)
    );

    pipelined_csel_adder #(.WIDTH(8), .BLK(2)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(rv), .in_ready(ir8),
        .a(a8), .b(b8), .c_in(ci8),
`ifdef CSEL_SUB_EN
        .sub(1'b0),
`endif
        .out_valid(ov8), .out_ready(rr),
        .sum(s8), .c_out(co8), .ovf(of8)
    );

    pipelined_csel_adder #(.WIDTH(32), .BLK(8)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(rv), .in_ready(ir32),
        .a(a32), .b(b32), .c_in(ci32),
`ifdef CSEL_SUB_EN
        .sub(1'b0),
`endif
        .out_valid(ov32), .out_ready(rr),
        .sum(s32), .c_out(co32), .ovf(of32)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        ci;
        logic        sb;
        logic [15:0] s;
        logic        co;
        logic        ov;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic [15:0] va, input logic [15:0] vb, input logic vci,
                                input logic vsb, input logic [15:0] vs, input logic vco,
                                input logic vov);
        vec_t v;
        v.a = va; v.b = vb; v.ci = vci; v.sb = vsb; v.s = vs; v.co = vco; v.ov = vov;
        return v;
    endfunction

    // Result packed as {ovf, c_out, zero-extended sum}.
    function automatic logic [33:0] ref_add(input int w, input logic [31:0] x,
                                            input logic [31:0] y, input logic ci);
        logic [32:0] t;
        logic [31:0] s;
        t = {1'b0, x} + {1'b0, y} + {32'd0, ci};
        s = t[31:0];
        for (int k = w; k < 32; k++) s[k] = 1'b0;
        return {(x[w-1] == y[w-1]) && (t[w-1] != x[w-1]), t[w], s};
    endfunction

    task automatic chk(input string nm, input logic [33:0] act, input logic [33:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic apply_vec(input vec_t v, input int idx);
        @(negedge clk);
        a = v.a; b = v.b; c_in = v.ci; in_valid = 1'b1; out_ready = 1'b1;
`ifdef CSEL_SUB_EN
        sub = v.sb;
`endif
        @(negedge clk);
        in_valid = 1'b0;
        chk($sformatf("vec%0d_latency", idx), 34'(out_valid), 34'd0);
        @(negedge clk);
        chk($sformatf("vec%0d_valid", idx), 34'(out_valid), 34'd1);
        chk($sformatf("vec%0d_sum", idx), 34'(sum), 34'(v.s));
        chk($sformatf("vec%0d_cout", idx), 34'(c_out), 34'(v.co));
        chk($sformatf("vec%0d_ovf", idx), 34'(ovf), 34'(v.ov));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [33:0] q16[$];
        logic [33:0] q8[$];
        logic [33:0] q32[$];
        logic [33:0] held;
        logic        held_v;
        logic        saw_stall;
        int          sent, got;

        in_valid = 1'b0; a = '0; b = '0; c_in = 1'b0; out_ready = 1'b1;
`ifdef CSEL_SUB_EN
        sub = 1'b0;
`endif
        rv = 1'b0; rr = 1'b1; a8 = '0; b8 = '0; ci8 = 1'b0; a32 = '0; b32 = '0; ci32 = 1'b0;

        tbl.push_back(mk(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0));
        tbl.push_back(mk(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1));
        tbl.push_back(mk(16'h1234, 16'h0F0F, 1'b1, 1'b0, 16'h2144, 1'b0, 1'b0));
        tbl.push_back(mk(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1));
        tbl.push_back(mk(16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0));
        tbl.push_back(mk(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0));
        tbl.push_back(mk(16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0));
        tbl.push_back(mk(16'h0FFF, 16'h0000, 1'b1, 1'b0, 16'h1000, 1'b0, 1'b0));
        tbl.push_back(mk(16'h7FFF, 16'h7FFF, 1'b1, 1'b0, 16'hFFFF, 1'b0, 1'b1));
        tbl.push_back(mk(16'hA5A5, 16'h5A5A, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b0));
`ifdef CSEL_SUB_EN
        tbl.push_back(mk(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0));
        tbl.push_back(mk(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1));
        tbl.push_back(mk(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0));
        tbl.push_back(mk(16'h0005, 16'h0007, 1'b1, 1'b0, 16'h000D, 1'b0, 1'b0));
`endif

        // Reset state
        @(negedge clk);
        chk("rst_out_valid", 34'(out_valid), 34'd0);
        chk("rst_sum", 34'(sum), 34'd0);
        chk("rst_cout_ovf", 34'({c_out, ovf}), 34'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("rst_in_ready", 34'(in_ready), 34'd1);

        foreach (tbl[i]) apply_vec(tbl[i], i);

        // Back-to-back stream with a four-cycle output stall
        sent = 0; got = 0; held_v = 1'b0; saw_stall = 1'b0; held = '0;
        for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
            @(negedge clk);
            out_ready = !(cyc >= 3 && cyc <= 6);
            in_valid  = (sent < 8);
            a    = 16'(sent * 16'h1357 + 16'h0F0F);
            b    = 16'(16'hF0F0 ^ (sent * 16'h2469));
            c_in = sent[0];
            #1;
            if (held_v) begin
                chk("stall_hold", {ovf, c_out, 16'd0, sum}, held);
                held_v = 1'b0;
            end
            if (!in_ready) saw_stall = 1'b1;
            if (out_valid && out_ready) begin
                if (q16.size() == 0) chk("stream_extra", 34'(got), 34'd8);
                else chk("stream_order", {ovf, c_out, 16'd0, sum}, q16.pop_front());
                got++;
            end else if (out_valid) begin
                held   = {ovf, c_out, 16'd0, sum};
                held_v = 1'b1;
            end
            if (in_valid && in_ready) begin
                q16.push_back(ref_add(16, 32'(a), 32'(b), c_in));
                sent++;
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        chk("stream_delivered", 34'(got), 34'd8);
        chk("stream_stall_seen", 34'(saw_stall), 34'd1);

        // Reset with two beats in flight
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; a = 16'h0001; b = 16'h0002; c_in = 1'b0;
        @(negedge clk);
        a = 16'h0003;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("pre_rst_valid", 34'(out_valid), 34'd1);
        chk("pre_rst_sum", 34'(sum), 34'h3);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 34'(out_valid), 34'd0);
        chk("async_rst_sum", 34'(sum), 34'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        #1 chk("post_rst_in_ready", 34'(in_ready), 34'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("no_stale_beat", 34'(out_valid), 34'd0);
        end

        // Random streams on the 8/2 and 32/8 instances with random backpressure
        for (int cyc = 0; cyc < 1520; cyc++) begin
            @(negedge clk);
            if (cyc < 1500) begin
                rv = ($urandom_range(0, 3) != 0);
                rr = ($urandom_range(0, 2) != 0);
            end else begin
                rv = 1'b0;
                rr = 1'b1;
            end
            a8 = 8'($urandom_range(0, 255)); b8 = 8'($urandom_range(0, 255));
            ci8 = 1'($urandom_range(0, 1));
            a32 = $urandom; b32 = $urandom; ci32 = 1'($urandom_range(0, 1));
            #1;
            if (ov8 && rr) begin
                if (q8.size() == 0) chk("rand8_extra", 34'(ov8), 34'd0);
                else chk("rand8", {of8, co8, 24'd0, s8}, q8.pop_front());
            end
            if (ov32 && rr) begin
                if (q32.size() == 0) chk("rand32_extra", 34'(ov32), 34'd0);
                else chk("rand32", {of32, co32, s32}, q32.pop_front());
            end
            if (rv && ir8) q8.push_back(ref_add(8, 32'(a8), 32'(b8), ci8));
            if (rv && ir32) q32.push_back(ref_add(32, a32, b32, ci32));
        end
        chk("rand8_drained", 34'(q8.size()), 34'd0);
        chk("rand32_drained", 34'(q32.size()), 34'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipelined_csel_adder.md
PIPELINED_CSEL_ADDER -- requirements
Module: pipelined_csel_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/sum width in bits.
REQ-002 SHALL have parameter BLK, default 4, carry-select block width; WIDTH SHALL be an integer multiple of BLK, elaboration error otherwise.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  operand beat present.
REQ-006 in_ready  output  1  block accepts beat this cycle.
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B.
REQ-009 c_in  input  1  carry-in.
REQ-010 out_valid  output  1  result beat present.
REQ-011 out_ready  input  1  downstream accepts result.
REQ-012 sum  output  WIDTH  result, modulo 2^WIDTH.
REQ-013 c_out  output  1  carry out of bit WIDTH-1.
REQ-014 ovf  output  1  two's-complement signed overflow.

Function
REQ-015 Stage 1 SHALL, per BLK-bit block, compute and register both conditional sums and carries (carry-in 0 and carry-in 1), plus the captured c_in.
REQ-016 Stage 2 SHALL resolve block carries LSB-to-MSB by selecting each block's precomputed pair on the previous block's resolved carry (block 0 uses registered c_in), and register sum, c_out, ovf.
REQ-017 ovf SHALL equal carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
REQ-018 Latency SHALL be 2 cycles from accepted beat to out_valid with no backpressure; throughput one beat per cycle.
REQ-019 A beat SHALL transfer on input when in_valid && in_ready, on output when out_valid && out_ready.
REQ-020 Stage 2 SHALL load when (!out_valid || out_ready); stage 1 SHALL advance into stage 2 only under that condition.
REQ-021 in_ready SHALL equal (!s1_valid || stage-2 load condition); combinational from out_ready, no combinational path from in_valid.
REQ-022 While out_valid && !out_ready, sum/c_out/ovf SHALL hold stable and no beat SHALL be dropped or duplicated.
REQ-023 Simultaneous output drain and input accept with both stages full SHALL proceed without bubble.
REQ-024 Beats SHALL emerge in acceptance order.

Reset
REQ-025 rst_n low SHALL immediately clear s1_valid and out_valid to 0 and sum, c_out, ovf to 0, regardless of clock.
REQ-026 Reset asserted mid-operation SHALL discard all in-flight beats; in_ready SHALL read 1 from the first cycle after rst_n deasserts.

Configuration
REQ-027 Macro CSEL_SUB_EN: when defined, input port sub (1 bit) SHALL exist; sub=1 SHALL compute a + ~b + 1 (c_in ignored), sub=0 SHALL compute a + b + c_in; sub captured with the beat.
REQ-028 Without CSEL_SUB_EN, port sub SHALL be absent and the block SHALL always compute a + b + c_in.

Verification
REQ-029 WIDTH=16: a=0xFFFF, b=0x0001, c_in=0, out_ready=1 -> 2 cycles later sum=0x0000, c_out=1, ovf=0.
REQ-030 a=0x7FFF, b=0x0001, c_in=0 -> sum=0x8000, c_out=0, ovf=1; a=0x1234, b=0x0F0F, c_in=1 -> sum=0x2144, c_out=0.
REQ-031 Stream 8 beats back-to-back, out_ready=0 for cycles 3-6 -> in_ready falls once both stages full, outputs held, all 8 results delivered in order, none lost.
REQ-032 Assert rst_n=0 with two beats in flight -> out_valid=0, sum=0 immediately; no stale beat appears after release.
REQ-033 With CSEL_SUB_EN: a=0x0005, b=0x0007, sub=1 -> sum=0xFFFE, c_out=0, ovf=0; a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, ovf=1.
REQ-034 Exhaustive random compare vs reference a+b+c_in for WIDTH=8/BLK=2 and WIDTH=32/BLK=8 with random out_ready -> zero mismatches.
